fft64_peak_detect: RTL and testbench
====================================

# fft64_peak_detect

Streaming post-processor that sits directly downstream of the 64-point FFT core and consumes its natural-order output stream (RDY, ADDR, DOR, DOI, OVF1, OVF2). For every 64-bin frame it computes the squared magnitude of each bin, tracks the strongest bin, and reports the peak index, peak power and frame status with a one-cycle valid pulse. It has no backpressure; it accepts one bin per ED-qualified cycle.

## Interface
- DW, 19, signed width of DOR/DOI
- AW, 6, bin address width (64 bins)
- PW, 38, unsigned power width (2*DW; holds 2*(2^18)^2 = 2^37 exactly)
- EXCL_DC, 0, 1 = bin 0 is never a peak candidate

- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- ED  in  1  data enable; one bin is accepted per cycle with ED=1
- RDY  in  1  FFT frame marker; high on the ED cycle carrying bin 0
- ADDR  in  AW  bin index of current DOR/DOI
- DOR, DOI  in  DW each  signed real/imag bin value
- OVF1, OVF2  in  1 each  FFT overflow flags, sampled on accepted cycles
- PK_VLD  out  1  one-cycle pulse, frame result valid
- PK_BIN  out  AW  index of peak bin
- PK_PWR  out  PW  DOR^2+DOI^2 of peak bin
- PK_OVF  out  1  OR of OVF1|OVF2 over the frame's 64 accepted cycles
- PK_ERR  out  1  at least one ADDR != expected index in the frame
- ABORT_CNT  out  8  saturating count of aborted frames

## Operation
- Frame FSM, states IDLE and ACC; internal expected-index counter IDX (AW bits).
- IDLE: ED=1 & RDY=1 → accept as bin 0, IDX←1, go ACC. ED=1 & RDY=0 → sample ignored, stay IDLE.
- ACC: ED=1 & RDY=0 → accept as bin IDX, IDX←IDX+1. Accept with IDX=63 → frame complete, go IDLE.
- ACC: ED=1 & RDY=1 → abort: in-flight frame is discarded (no PK_VLD), ABORT_CNT+1 (saturates at 255), current sample accepted as bin 0 of a new frame, IDX←1.
- ED=0 cycles: FSM and IDX hold; in-flight pipeline stages still drain.
- Bin identity is IDX, not ADDR; ADDR != IDX on an accepted cycle sets the frame error flag only.
- Each accepted sample enters the magnitude pipeline tagged first (bin 0), last (bin 63), bin index, and frame-kill state.
- Compare stage: on first, peak←(power, 0) unless EXCL_DC=1, in which case peak←(0, 0) with candidate disabled; on subsequent bins, replace only if power > peak power (strict; ties keep lowest index).
- Arithmetic: squares signed DW×DW → unsigned 2*DW-1 bits; sum zero-extended to PW; no saturation needed. (-2^18)^2 is handled exactly.
- Back-to-back frames (bin 0 on the cycle after bin 63) are fully supported with no lost bins.

## Timing
- Reset: all outputs 0, FSM IDLE, IDX 0, pipeline valid tags cleared, ABORT_CNT 0.
- Pipeline: accept cycle T → squares registered T+1 → sum registered T+2 → compare/peak register T+3.
- PK_VLD high exactly in cycle T+3 where T is the cycle accepting bin 63; PK_BIN/PK_PWR/PK_OVF/PK_ERR valid in that cycle and held until the next PK_VLD.
- Latency is fixed regardless of ED after T.
- Abort at cycle T kills all older in-flight samples; no PK_VLD for them even if their last stage completes later.
- RST mid-frame: in-flight frame dropped, no PK_VLD, held outputs cleared.

## Structure
- Shared package fft64_pkg: DW, AW, NBINS=64, PW constants; FSM state enum (IDLE, ACC).
- Sub-module fft64_mag2: two-stage registered DOR^2+DOI^2 pipeline with pass-through tag bus.
- Top holds FSM, IDX, error/overflow accumulation, compare stage and ABORT_CNT.

## Test plan
- Single frame, bin k=(k==17 ? DOR=1000,DOI=-1000 : DOR=k,DOI=0), ED=1 continuous → PK_VLD 3 cycles after bin 63, PK_BIN=17, PK_PWR=2000000, PK_OVF=0, PK_ERR=0.
- Bins 5 and 40 both DOR=-262144, DOI=-262144, others 0 → PK_BIN=5, PK_PWR=2^37.
- EXCL_DC=1, bin 0 DOR=30000, bin 9 DOR=3 → PK_BIN=9, PK_PWR=9; with EXCL_DC=0 → PK_BIN=0.
- ED toggling 1/0 throughout, OVF2 high on bin 30, ADDR forced to 0 on bin 12 → same peak as gapless run, PK_OVF=1, PK_ERR=1.
- RDY at bin 20 then a full 64-bin frame → ABORT_CNT=1, exactly one PK_VLD; back-to-back second frame → two PK_VLD pulses 64 cycles apart.
- RST asserted at bin 62 → no PK_VLD, all outputs 0 next cycle.

Source files
------------

// File: rtl/fft64_pkg.sv
// Shared constants, FSM state and per-sample tag layout for the FFT64 peak detector.
package fft64_pkg;

  localparam int DW    = 19;
  localparam int AW    = 6;
  localparam int NBINS = 64;
  localparam int PW    = 2 * DW;
  localparam int SQW   = 2 * DW - 1;

  typedef enum logic {
    IDLE,
    ACC
  } state_t;

  // fid identifies which frame a sample belongs to, so an abort can kill only its own frame
  typedef struct packed {
    logic          first;
    logic          last;
    logic [AW-1:0] bin;
    logic          ovf;
    logic          err;
    logic          fid;
  } tag_t;

endpackage

// File: rtl/fft64_peak_detect_if.sv
// FFT output stream into the peak detector and the per-frame peak report back out.
interface fft64_peak_detect_if;
  import fft64_pkg::*;

  logic                 ED;
  logic                 RDY;
  logic [AW-1:0]        ADDR;
  logic signed [DW-1:0] DOR;
  logic signed [DW-1:0] DOI;
  logic                 OVF1;
  logic                 OVF2;

  logic                 PK_VLD;
  logic [AW-1:0]        PK_BIN;
  logic [PW-1:0]        PK_PWR;
  logic                 PK_OVF;
  logic                 PK_ERR;
  logic [7:0]           ABORT_CNT;

  modport master (
    output ED, RDY, ADDR, DOR, DOI, OVF1, OVF2,
    input  PK_VLD, PK_BIN, PK_PWR, PK_OVF, PK_ERR, ABORT_CNT
  );

  modport slave (
    input  ED, RDY, ADDR, DOR, DOI, OVF1, OVF2,
    output PK_VLD, PK_BIN, PK_PWR, PK_OVF, PK_ERR, ABORT_CNT
  );

endinterface

// File: rtl/fft64_mag2.sv
// Two-stage registered DOR^2 + DOI^2 with a tag bus travelling alongside the data.
module fft64_mag2
  import fft64_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 flush_fid,
  input  logic                 in_vld,
  input  logic signed [DW-1:0] dr,
  input  logic signed [DW-1:0] di,
  input  tag_t                 in_tag,
  output logic                 out_vld,
  output logic [PW-1:0]        out_pwr,
  output tag_t                 out_tag
);

  logic signed [2*DW-1:0] prod_r;
  logic signed [2*DW-1:0] prod_i;
  logic [SQW-1:0]         sq_r_q;
  logic [SQW-1:0]         sq_i_q;
  logic                   s1_vld_q;
  tag_t                   s1_tag_q;
  logic                   s2_vld_q;
  logic [PW-1:0]          s2_pwr_q;
  tag_t                   s2_tag_q;

  // A square is never negative and (-2^18)^2 = 2^36 still fits below the sign bit
  assign prod_r = dr * dr;
  assign prod_i = di * di;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      sq_r_q   <= '0;
      sq_i_q   <= '0;
      s1_tag_q <= '0;
      s2_vld_q <= 1'b0;
      s2_pwr_q <= '0;
      s2_tag_q <= '0;
    end else begin
      s1_vld_q <= in_vld;
      sq_r_q   <= prod_r[SQW-1:0];
      sq_i_q   <= prod_i[SQW-1:0];
      s1_tag_q <= in_tag;
      s2_vld_q <= s1_vld_q && !(flush && (s1_tag_q.fid == flush_fid));
      s2_pwr_q <= {1'b0, sq_r_q} + {1'b0, sq_i_q};
      s2_tag_q <= s1_tag_q;
    end
  end

  assign out_vld = s2_vld_q;
  assign out_pwr = s2_pwr_q;
  assign out_tag = s2_tag_q;

endmodule

// File: rtl/fft64_peak_detect.sv
// Frame tracker and peak search over the natural-order output of the 64-point FFT.
module fft64_peak_detect
  import fft64_pkg::*;
#(
  parameter bit EXCL_DC = 1'b0
)
(
  input logic                CLK,
  input logic                RST,
  fft64_peak_detect_if.slave bus
);

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] idx_q;
  logic          fid_q;
  logic [7:0]    abort_cnt_q;

  logic          accept;
  logic          first;
  logic          last;
  logic          abort;
  logic [AW-1:0] bin_cur;
  tag_t          tag_in;

  logic          s2_vld;
  logic [PW-1:0] s2_pwr;
  tag_t          s2_tag;
  logic          s2_use;

  logic [PW-1:0] peak_pwr_q;
  logic [AW-1:0] peak_bin_q;
  logic          ovf_acc_q;
  logic          err_acc_q;
  logic [PW-1:0] cand_pwr;
  logic [AW-1:0] cand_bin;
  logic          cand_ovf;
  logic          cand_err;

  logic          pk_vld_q;
  logic [AW-1:0] pk_bin_q;
  logic [PW-1:0] pk_pwr_q;
  logic          pk_ovf_q;
  logic          pk_err_q;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.ED) begin
      case (state_q)
        IDLE: if (bus.RDY) state_d = ACC;
        ACC: begin
          if (bus.RDY)                          state_d = ACC;
          else if (idx_q == AW'(NBINS - 1))     state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    accept = 1'b0;
    first  = 1'b0;
    abort  = 1'b0;
    last   = 1'b0;
    if (bus.ED) begin
      first  = bus.RDY;
      abort  = bus.RDY && (state_q == ACC);
      accept = bus.RDY || (state_q == ACC);
      last   = accept && !bus.RDY && (idx_q == AW'(NBINS - 1));
    end
  end

  assign bin_cur = first ? '0 : idx_q;

  always_comb begin
    tag_in       = '0;
    tag_in.first = first;
    tag_in.last  = last;
    tag_in.bin   = bin_cur;
    tag_in.ovf   = bus.OVF1 | bus.OVF2;
    tag_in.err   = (bus.ADDR != bin_cur);
    tag_in.fid   = first ? ~fid_q : fid_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q       <= '0;
      fid_q       <= 1'b0;
      abort_cnt_q <= '0;
    end else begin
      if (first)       idx_q <= AW'(1);
      else if (accept) idx_q <= idx_q + AW'(1);
      if (first)       fid_q <= ~fid_q;
      if (abort && (abort_cnt_q != 8'hFF)) abort_cnt_q <= abort_cnt_q + 8'd1;
    end
  end

  fft64_mag2 u_mag2 (
    .clk       (CLK),
    .rst       (RST),
    .flush     (abort),
    .flush_fid (fid_q),
    .in_vld    (accept),
    .dr        (bus.DOR),
    .di        (bus.DOI),
    .in_tag    (tag_in),
    .out_vld   (s2_vld),
    .out_pwr   (s2_pwr),
    .out_tag   (s2_tag)
  );

  // A sample of the frame being aborted this cycle must not reach the peak registers
  assign s2_use = s2_vld && !(abort && (s2_tag.fid == fid_q));

  always_comb begin
    cand_pwr = peak_pwr_q;
    cand_bin = peak_bin_q;
    cand_ovf = ovf_acc_q | s2_tag.ovf;
    cand_err = err_acc_q | s2_tag.err;
    if (s2_tag.first) begin
      cand_pwr = EXCL_DC ? '0 : s2_pwr;
      cand_bin = '0;
      cand_ovf = s2_tag.ovf;
      cand_err = s2_tag.err;
    end else if (s2_pwr > peak_pwr_q) begin
      cand_pwr = s2_pwr;
      cand_bin = s2_tag.bin;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      peak_pwr_q <= '0;
      peak_bin_q <= '0;
      ovf_acc_q  <= 1'b0;
      err_acc_q  <= 1'b0;
      pk_vld_q   <= 1'b0;
      pk_bin_q   <= '0;
      pk_pwr_q   <= '0;
      pk_ovf_q   <= 1'b0;
      pk_err_q   <= 1'b0;
    end else begin
      pk_vld_q <= 1'b0;
      if (s2_use) begin
        peak_pwr_q <= cand_pwr;
        peak_bin_q <= cand_bin;
        ovf_acc_q  <= cand_ovf;
        err_acc_q  <= cand_err;
        if (s2_tag.last) begin
          pk_vld_q <= 1'b1;
          pk_bin_q <= cand_bin;
          pk_pwr_q <= cand_pwr;
          pk_ovf_q <= cand_ovf;
          pk_err_q <= cand_err;
        end
      end
    end
  end

  assign bus.PK_VLD    = pk_vld_q;
  assign bus.PK_BIN    = pk_bin_q;
  assign bus.PK_PWR    = pk_pwr_q;
  assign bus.PK_OVF    = pk_ovf_q;
  assign bus.PK_ERR    = pk_err_q;
  assign bus.ABORT_CNT = abort_cnt_q;

endmodule

// File: tb/tb_fft64_peak_detect.sv
// Directed bench for fft64_peak_detect: two instances (bin 0 eligible / excluded) fed the same stream.
module tb_fft64_peak_detect;
  import fft64_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  fft64_peak_detect_if bus ();
  fft64_peak_detect_if bus_dc ();

  fft64_peak_detect #(.EXCL_DC(1'b0)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  fft64_peak_detect #(.EXCL_DC(1'b1)) dut_dc (.CLK(CLK), .RST(RST), .bus(bus_dc));

  always #5 CLK = ~CLK;

  always_comb begin
    bus_dc.ED   = bus.ED;
    bus_dc.RDY  = bus.RDY;
    bus_dc.ADDR = bus.ADDR;
    bus_dc.DOR  = bus.DOR;
    bus_dc.DOI  = bus.DOI;
    bus_dc.OVF1 = bus.OVF1;
    bus_dc.OVF2 = bus.OVF2;
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_cyc = 0;
  int vld_cnt = 0;
  int vld_cnt_dc = 0;
  int vld_cyc = 0;
  int vld_cyc_prev = 0;
  int v0 = 0;
  logic [AW-1:0] cap_bin[$];
  logic [DW-1:0] dr_tab[3][64];
  logic [DW-1:0] di_tab[3][64];

  always @(posedge CLK) cyc++;

  // Pulse bookkeeping is sampled mid-cycle, well away from the rising edge
  always @(negedge CLK) begin
    if (bus.PK_VLD === 1'b1) begin
      vld_cnt++;
      vld_cyc_prev = vld_cyc;
      vld_cyc = cyc;
      cap_bin.push_back(bus.PK_BIN);
    end
    if (bus_dc.PK_VLD === 1'b1) vld_cnt_dc++;
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic ed, input logic rdy, input logic [AW-1:0] addr,
                                input logic [DW-1:0] dr, input logic [DW-1:0] di,
                                input logic o1, input logic o2);
    bus.ED   = ed;
    bus.RDY  = rdy;
    bus.ADDR = addr;
    bus.DOR  = dr;
    bus.DOI  = di;
    bus.OVF1 = o1;
    bus.OVF2 = o2;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // Sends bins 0..63 of a table; stop_at ends the frame early, gaps inserts ED=0 cycles with junk
  task automatic run_frame(input int tab, input bit gaps, input int bad_addr_bin,
                           input int ovf_bin, input int stop_at);
    for (int k = 0; k < 64; k++) begin
      if (k == stop_at) return;
      if (k == 63) last_cyc = cyc;
      apply_stimulus(1'b1, k == 0, (k == bad_addr_bin) ? '0 : AW'(k),
                     dr_tab[tab][k], di_tab[tab][k], 1'b0, k == ovf_bin);
      if (gaps) apply_stimulus(1'b0, 1'b1, AW'($urandom), DW'($urandom), DW'($urandom), 1'b1, 1'b1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_vld"}, 64'(bus.PK_VLD), 64'd0);
    check_output({tag, "_bin"}, 64'(bus.PK_BIN), 64'd0);
    check_output({tag, "_pwr"}, 64'(bus.PK_PWR), 64'd0);
    check_output({tag, "_ovf"}, 64'(bus.PK_OVF), 64'd0);
    check_output({tag, "_err"}, 64'(bus.PK_ERR), 64'd0);
    check_output({tag, "_abort"}, 64'(bus.ABORT_CNT), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      dr_tab[0][k] = DW'(k);
      di_tab[0][k] = '0;
      dr_tab[1][k] = '0;
      di_tab[1][k] = '0;
      dr_tab[2][k] = '0;
      di_tab[2][k] = '0;
    end
    dr_tab[0][17] = DW'(1000);
    di_tab[0][17] = DW'(-1000);
    dr_tab[1][5]  = DW'(-262144);
    di_tab[1][5]  = DW'(-262144);
    dr_tab[1][40] = DW'(-262144);
    di_tab[1][40] = DW'(-262144);
    dr_tab[2][0]  = DW'(30000);
    dr_tab[2][9]  = DW'(3);

    RST = 1'b1;
    idle(3);
    check_all_zero("reset");
    RST = 1'b0;
    idle(2);

    $display("[TB] single frame, peak at bin 17");
    v0 = vld_cnt;
    run_frame(0, 1'b0, -1, -1, -1);
    idle(5);
    check_output("a_pulses", 64'(vld_cnt - v0), 64'd1);
    check_output("a_latency", 64'(vld_cyc - last_cyc), 64'd3);
    check_output("a_bin", 64'(bus.PK_BIN), 64'd17);
    check_output("a_pwr", 64'(bus.PK_PWR), 64'd2000000);
    check_output("a_ovf", 64'(bus.PK_OVF), 64'd0);
    check_output("a_err", 64'(bus.PK_ERR), 64'd0);
    check_output("a_vld_low", 64'(bus.PK_VLD), 64'd0);

    $display("[TB] full-scale tie, bins 5 and 40");
    run_frame(1, 1'b0, -1, -1, -1);
    idle(5);
    check_output("b_bin", 64'(bus.PK_BIN), 64'd5);
    check_output("b_pwr", 64'(bus.PK_PWR), 64'd137438953472);

    $display("[TB] dc bin eligible vs excluded");
    v0 = vld_cnt_dc;
    run_frame(2, 1'b0, -1, -1, -1);
    idle(5);
    check_output("c_bin", 64'(bus.PK_BIN), 64'd0);
    check_output("c_pwr", 64'(bus.PK_PWR), 64'd900000000);
    check_output("c_dc_bin", 64'(bus_dc.PK_BIN), 64'd9);
    check_output("c_dc_pwr", 64'(bus_dc.PK_PWR), 64'd9);
    check_output("c_dc_pulses", 64'(vld_cnt_dc - v0), 64'd1);

    $display("[TB] gapped frame with overflow and address error");
    v0 = vld_cnt;
    run_frame(0, 1'b1, 12, 30, -1);
    idle(5);
    check_output("d_pulses", 64'(vld_cnt - v0), 64'd1);
    check_output("d_latency", 64'(vld_cyc - last_cyc), 64'd3);
    check_output("d_bin", 64'(bus.PK_BIN), 64'd17);
    check_output("d_pwr", 64'(bus.PK_PWR), 64'd2000000);
    check_output("d_ovf", 64'(bus.PK_OVF), 64'd1);
    check_output("d_err", 64'(bus.PK_ERR), 64'd1);

    $display("[TB] abort at bin 20 then full frame");
    v0 = vld_cnt;
    run_frame(1, 1'b0, -1, -1, 20);
    run_frame(0, 1'b0, -1, -1, -1);
    idle(5);
    check_output("e_abort", 64'(bus.ABORT_CNT), 64'd1);
    check_output("e_pulses", 64'(vld_cnt - v0), 64'd1);
    check_output("e_bin", 64'(bus.PK_BIN), 64'd17);
    check_output("e_pwr", 64'(bus.PK_PWR), 64'd2000000);
    check_output("e_err", 64'(bus.PK_ERR), 64'd0);

    $display("[TB] back-to-back frames");
    v0 = vld_cnt;
    run_frame(0, 1'b0, -1, -1, -1);
    run_frame(1, 1'b0, -1, -1, -1);
    idle(5);
    check_output("f_pulses", 64'(vld_cnt - v0), 64'd2);
    check_output("f_spacing", 64'(vld_cyc - vld_cyc_prev), 64'd64);
    if (cap_bin.size() > v0) check_output("f_first_bin", 64'(cap_bin[v0]), 64'd17);
    check_output("f_bin", 64'(bus.PK_BIN), 64'd5);
    check_output("f_pwr", 64'(bus.PK_PWR), 64'd137438953472);
    check_output("f_abort", 64'(bus.ABORT_CNT), 64'd1);

    $display("[TB] reset at bin 62");
    v0 = vld_cnt;
    run_frame(2, 1'b0, -1, -1, 62);
    RST = 1'b1;
    apply_stimulus(1'b1, 1'b0, 6'd62, dr_tab[2][62], di_tab[2][62], 1'b0, 1'b0);
    check_all_zero("g_rst");
    RST = 1'b0;
    apply_stimulus(1'b1, 1'b0, 6'd63, dr_tab[2][63], di_tab[2][63], 1'b0, 1'b0);
    idle(5);
    check_output("g_pulses", 64'(vld_cnt - v0), 64'd0);
    check_output("g_bin", 64'(bus.PK_BIN), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
